// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, RGB332 layout, cell-grid and swap-register constants
// for the VGA scanout path.
package vga_scanout_pkg;

   localparam logic [31:0] BASE_ADDR_DEF = 32'h0010_0000;

   localparam int H_ACT_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_ACT_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int CELL_SHIFT = 3;
   localparam int GRID_W_DEF = H_ACT_DEF >> CELL_SHIFT;
   localparam int GRID_H_DEF = V_ACT_DEF >> CELL_SHIFT;

   localparam int CNT_W = 10;

   localparam int R_MSB = 7;
   localparam int R_LSB = 5;
   localparam int G_MSB = 4;
   localparam int G_LSB = 2;
   localparam int B_MSB = 1;
   localparam int B_LSB = 0;

   localparam logic [31:0] SWAP_OFS = 32'h0000_FFFC;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WRITE,
      WR_ACK
   } wr_state_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

   function automatic int cell_idx(
      input logic [CNT_W-1:0] h,
      input logic [CNT_W-1:0] v,
      input int               gw
   );
      return int'(v >> CELL_SHIFT) * gw + int'(h >> CELL_SHIFT);
   endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// Free-running h/v counters and raw (undelayed) sync, enable and
// frame-start strobes.
module vga_scanout_timing
   import vga_scanout_pkg::*;
#(
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcnt_o,
   output logic [CNT_W-1:0] vcnt_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o,
   output logic             fstart_o
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;

   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == CNT_W'(H_TOT - 1)) begin
         hcnt_d = '0;
         if (vcnt_q == CNT_W'(V_TOT - 1)) vcnt_d = '0;
         else                             vcnt_d = vcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hcnt_o   = hcnt_q;
   assign vcnt_o   = vcnt_q;
   assign hsync_o  = !((hcnt_q >= CNT_W'(H_ACT + H_FP)) &&
                       (hcnt_q <  CNT_W'(H_ACT + H_FP + H_SYNC)));
   assign vsync_o  = !((vcnt_q >= CNT_W'(V_ACT + V_FP)) &&
                       (vcnt_q <  CNT_W'(V_ACT + V_FP + V_SYNC)));
   assign de_o     = (hcnt_q < CNT_W'(H_ACT)) && (vcnt_q < CNT_W'(V_ACT));
   assign fstart_o = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// RGB332 framebuffer with req/ack write port and 8x8-upscaled VGA scanout.
// Define VGA_DOUBLE_BUF_EN for front/back pages with a frame-synchronous swap.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] phy_addr,
   input  logic [31:0] phy_data,
   input  logic        hw_wr_req,
   output logic        hw_wr_ack,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic        frame_start
);

   localparam int GRID_W = H_ACT >> CELL_SHIFT;
   localparam int CELLS  = GRID_W * (V_ACT >> CELL_SHIFT);
`ifdef VGA_DOUBLE_BUF_EN
   localparam int PAGES  = 2;
`else
   localparam int PAGES  = 1;
`endif
   localparam int DEPTH  = PAGES * CELLS;
   localparam int AW     = $clog2(DEPTH);

   logic [CNT_W-1:0] hcnt, vcnt;
   sync_t            raw;

   vga_scanout_timing #(
      .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk      (clk),
      .rst      (rst),
      .hcnt_o   (hcnt),
      .vcnt_o   (vcnt),
      .hsync_o  (raw.hs),
      .vsync_o  (raw.vs),
      .de_o     (raw.de),
      .fstart_o (raw.fs)
   );

   wr_state_e   state_q;
   logic [31:0] addr_q;
   logic [7:0]  data_q;
   logic        ack_q;
   logic [31:0] offset;
   logic        wr_en;
   logic        unused_hi;

   assign unused_hi = ^phy_data[31:8];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WR_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         unique case (state_q)
            WR_IDLE: if (hw_wr_req) begin
               addr_q  <= phy_addr;
               data_q  <= phy_data[7:0];
               state_q <= WR_WRITE;
            end
            WR_WRITE: begin
               ack_q   <= 1'b1;
               state_q <= WR_ACK;
            end
            WR_ACK: if (!hw_wr_req) begin
               ack_q   <= 1'b0;
               state_q <= WR_IDLE;
            end
            default: state_q <= WR_IDLE;
         endcase
      end
   end

   // Below-base addresses wrap to huge offsets and fail the range test
   assign offset    = addr_q - BASE_ADDR;
   assign wr_en     = (state_q == WR_WRITE) && (offset < 32'(CELLS));
   assign hw_wr_ack = ack_q;

   logic [AW-1:0] wr_idx, rd_idx;
   int            rd_cell;

   assign rd_cell = cell_idx(hcnt, vcnt, GRID_W);

`ifdef VGA_DOUBLE_BUF_EN
   logic front_q, armed_q, swap_wr;

   assign swap_wr = (state_q == WR_WRITE) && (offset == SWAP_OFS) && data_q[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         front_q <= 1'b0;
         armed_q <= 1'b0;
      end else if (raw.fs && armed_q) begin
         front_q <= ~front_q;
         armed_q <= swap_wr;
      end else if (swap_wr) begin
         armed_q <= 1'b1;
      end
   end

   assign wr_idx = AW'(offset + (front_q ? 32'd0 : 32'(CELLS)));
   assign rd_idx = AW'(rd_cell + (front_q ? CELLS : 0));
`else
   assign wr_idx = AW'(offset);
   assign rd_idx = AW'(rd_cell);
`endif

   logic [7:0] fb_q [DEPTH];
   logic [7:0] rd_q;

   // Non-blocking read of a cell written this cycle yields the old value
   always_ff @(posedge clk) begin
      if (wr_en)  fb_q[wr_idx] <= data_q;
      if (raw.de) rd_q <= fb_q[rd_idx];
   end

   sync_t      s1_q, s2_q;
   logic [7:0] pix_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q  <= SYNC_IDLE;
         s2_q  <= SYNC_IDLE;
         pix_q <= '0;
      end else begin
         s1_q  <= raw;
         s2_q  <= s1_q;
         pix_q <= s1_q.de ? rd_q : 8'h00;
      end
   end

   assign hsync       = s2_q.hs;
   assign vsync       = s2_q.vs;
   assign de          = s2_q.de;
   assign frame_start = s2_q.fs;
   assign red         = pix_q[R_MSB:R_LSB];
   assign green       = pix_q[G_MSB:G_LSB];
   assign blue        = pix_q[B_MSB:B_LSB];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 64x32 raster (8x4 cells);
// expected frame images are queued at stimulus time and checked pixel by pixel.
module tb_vga_scanout;

   localparam int HA = 64, HF = 8, HS = 12, HB = 4;
   localparam int VA = 32, VF = 3, VS = 2,  VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int GW = HA / 8;
   localparam int NC = GW * (VA / 8);
   localparam logic [31:0] BASE = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] phy_addr = '0;
   logic [31:0] phy_data = '0;
   logic        hw_wr_req = 1'b0;
   logic        hw_wr_ack, hsync, vsync, de, frame_start;
   logic [2:0]  red, green;
   logic [1:0]  blue;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] mfb [2][NC];
   int         m_front = 0;
   logic       m_armed = 1'b0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   vga_scanout #(
      .H_ACT (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACT (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .phy_addr    (phy_addr),
      .phy_data    (phy_data),
      .hw_wr_req   (hw_wr_req),
      .hw_wr_ack   (hw_wr_ack),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_start (frame_start)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int back_page();
`ifdef VGA_DOUBLE_BUF_EN
      return 1 - m_front;
`else
      return 0;
`endif
   endfunction

   task automatic apply_swap();
      if (m_armed) begin
         m_front = 1 - m_front;
         m_armed = 1'b0;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      int n;
      logic [31:0] off;
      @(negedge clk);
      phy_addr  = a;
      phy_data  = d;
      hw_wr_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!hw_wr_ack && n < 8);
      chk("ack_latency", n, 2);
      hw_wr_req = 1'b0;
      @(negedge clk);
      chk("ack_drop", hw_wr_ack, 0);
      off = a - BASE;
      if (off < NC) mfb[back_page()][off[4:0]] = d[7:0];
`ifdef VGA_DOUBLE_BUF_EN
      else if (off == 32'h0000_FFFC && d[0]) m_armed = 1'b1;
`endif
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < NC; i++) wr(BASE + 32'(i), {24'h0, v});
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_start !== 1'b1 && n < 5000);
      chk("frame_start_seen", frame_start, 1);
      apply_swap();
   endtask

   task automatic push_img();
      for (int i = 0; i < NC; i++) exp_q.push_back(mfb[m_front][i]);
   endtask

   task automatic check_frame(input string tag);
      logic [7:0]  img [NC];
      logic [11:0] obs, exp;
      logic [7:0]  px;
      int x, y;
      chk({tag, "_queued"}, exp_q.size(), NC);
      for (int i = 0; i < NC; i++)
         img[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      wait_fs();
      for (int c = 0; c < HT * VT; c++) begin
         if (c > 0) @(negedge clk);
         x  = c % HT;
         y  = c / HT;
         px = (x < HA && y < VA) ? img[(y / 8) * GW + x / 8] : 8'h00;
         exp = {!(x >= HA + HF && x < HA + HF + HS),
                !(y >= VA + VF && y < VA + VF + VS),
                (x < HA && y < VA), (c == 0), px};
         obs = {hsync, vsync, de, frame_start, red, green, blue};
         chk(tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int pg;

      // Reset state
      #12;
      chk("reset_outputs", {hw_wr_ack, hsync, vsync, de, frame_start, red, green, blue},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk);
      rst = 1'b1;

      // First hsync fall: front porch end plus two pipeline stages
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (hsync && n < 200);
      chk("first_hsync_fall", n, HA + HF + 2);

      // Zero both pages (second fill lands on the other page after a swap)
      wait_fs();
      fill(8'h00);
      wr(BASE + 32'h0000_FFFC, 32'h1);
      wait_fs();
      fill(8'h00);
      push_img();
      check_frame("zero_frame");

      // Red cell 0
      wr(BASE, 32'hE0);
      push_img();
      check_frame("red_cell0");

      // Last cell blue
      wr(BASE + 32'(NC - 1), 32'h03);
      push_img();
      check_frame("blue_last");

      // Out-of-range writes are acknowledged but dropped
      wr(32'h0020_0000, 32'hFF);
      wr(BASE + 32'(NC), 32'hFF);
      wr(BASE - 32'h1, 32'hFF);
      push_img();
      check_frame("out_of_range");

      // Long request hold
      @(negedge clk);
      phy_addr  = BASE + 32'd5;
      phy_data  = 32'h42;
      hw_wr_req = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         chk("hold_ack", hw_wr_ack, 32'(i >= 2));
      end
      hw_wr_req = 1'b0;
      @(negedge clk);
      chk("hold_drop", hw_wr_ack, 0);
      mfb[back_page()][5] = 8'h42;

      // Reset while in ACK
      @(negedge clk);
      phy_addr  = BASE + 32'd6;
      phy_data  = 32'h55;
      hw_wr_req = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_reset_ack", hw_wr_ack, 1);
      pg = back_page();
      mfb[pg][6] = 8'h55;
      #2 rst = 1'b0;
      #1 chk("reset_ack_low", hw_wr_ack, 0);
      hw_wr_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_front = 0;
      m_armed = 1'b0;
      wr(BASE + 32'd7, 32'h66);
      push_img();
      check_frame("after_reset");

`ifdef VGA_DOUBLE_BUF_EN
      // Fill back page and arm the swap mid-frame
      wait_fs();
      push_img();
      fork
         check_frame("swap_cur");
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (frame_start !== 1'b1 && n < 5000);
            repeat (HT * 10) @(negedge clk);
            fill(8'h1C);
            wr(BASE + 32'h0000_FFFC, 32'h1);
         end
      join
      apply_swap();
      push_img();
      check_frame("swap_next");
`else
      fill(8'h1C);
      push_img();
      check_frame("green_fill");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
